dram_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of the DRAM controller's
//  L2/MEM port (mig_example_top, clk_cpu domain). Requester 0 is the L2

---
 rtl/dram_port_arbiter_pkg.sv | 21 ++
 rtl/dram_port_arbiter_rr.sv | 16 +
 rtl/dram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_dram_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and default widths for the L2/debug DRAM port arbiter.
// The defaults match the L2 cache and the mig wrapper line geometry.
package dram_port_arbiter_pkg;

   localparam int LINE_W_DEF      = 512;
   localparam int TAG_W_DEF       = 18;
   localparam int INDEX_W_DEF     = 8;
   localparam int TIMEOUT_CYC_DEF = 4096;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   // Index of a one-hot two-bit grant vector.
   function automatic logic onehot_idx(input logic [1:0] oh);
      return oh[1];
   endfunction

endpackage

// File: rtl/dram_port_arbiter_rr.sv
// Combinational two-way round-robin pick: on a tie the requester that
// did not win last time is chosen, otherwise the lone requester wins.
module dram_arb_rr (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] winner_o
);

   always_comb begin
      winner_o = req_i;
      if (req_i == 2'b11) begin
         winner_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter serialising whole-line L2 and debug transactions onto
// the DRAM controller port, with a sticky timeout flag for a hung controller.
module dram_port_arbiter
   import dram_port_arbiter_pkg::*;
#(
   parameter int LINE_W      = LINE_W_DEF,
   parameter int TAG_W       = TAG_W_DEF,
   parameter int INDEX_W     = INDEX_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [1:0]                    rd_i,
   input  logic [1:0]                    wr_i,
   input  logic [1:0][TAG_W-1:0]         tag_i,
   input  logic [1:0][INDEX_W-1:0]       index_i,
   input  logic [1:0][TAG_W-1:0]         wtag_i,
   input  logic [1:0][LINE_W-1:0]        wdata_i,
   output logic [LINE_W-1:0]             rdata_o,
   output logic [1:0]                    ready_o,
   output logic [1:0]                    grant_o,
   output logic                          err_o,
   output logic                          read_L2_MEM,
   output logic                          write_L2_MEM,
   output logic [TAG_W-1:0]              tag_L2_MEM,
   output logic [INDEX_W-1:0]            index_L2_MEM,
   output logic [TAG_W-1:0]              write_tag_L2_MEM,
   output logic [LINE_W-1:0]             write_data_L2_MEM,
   input  logic [LINE_W-1:0]             read_data_MEM_L2,
   input  logic                          ready_MEM_L2
);

   // A zero timeout disables the abort path, so keep the counter at least 1 bit wide.
   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   arb_state_e         state_q;
   logic               last_grant_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [1:0]         grant_q;
   logic [1:0]         ready_q;
   logic               err_q;
   logic [LINE_W-1:0]  rdata_q;
   logic               rd_q;
   logic               wr_q;
   logic [TAG_W-1:0]   tag_q;
   logic [INDEX_W-1:0] index_q;
   logic [TAG_W-1:0]   wtag_q;
   logic [LINE_W-1:0]  wdata_q;

   logic [1:0] pending;
   logic [1:0] winner;
   logic       sel;
   logic       timeoutHit;

   assign pending    = rd_i | wr_i;
   assign sel        = onehot_idx(winner);
   assign timeoutHit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   dram_arb_rr u_rr (
      .req_i        (pending),
      .last_grant_i (last_grant_q),
      .winner_o     (winner)
   );

   // Request fields are captured once in IDLE; later requester changes are ignored.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         grant_q      <= '0;
         ready_q      <= '0;
         err_q        <= 1'b0;
         rdata_q      <= '0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         tag_q        <= '0;
         index_q      <= '0;
         wtag_q       <= '0;
         wdata_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|pending) begin
                  rd_q         <= rd_i[sel];
                  wr_q         <= wr_i[sel];
                  tag_q        <= tag_i[sel];
                  index_q      <= index_i[sel];
                  wtag_q       <= wtag_i[sel];
                  wdata_q      <= wdata_i[sel];
                  grant_q      <= winner;
                  last_grant_q <= sel;
                  cnt_q        <= '0;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               if (ready_MEM_L2) begin
                  rdata_q <= read_data_MEM_L2;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  ready_q <= grant_q;
                  state_q <= DONE;
               end else if (timeoutHit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  ready_q <= grant_q;
                  state_q <= DONE;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               ready_q <= '0;
               grant_q <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rdata_o           = rdata_q;
   assign ready_o           = ready_q;
   assign grant_o           = grant_q;
   assign err_o             = err_q;
   assign read_L2_MEM       = rd_q;
   assign write_L2_MEM      = wr_q;
   assign tag_L2_MEM        = tag_q;
   assign index_L2_MEM      = index_q;
   assign write_tag_L2_MEM  = wtag_q;
   assign write_data_L2_MEM = wdata_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus random
// transactions compared against a transaction-level arbitration model.
module tb_dram_port_arbiter;

   localparam int LW = 512;
   localparam int TW = 18;
   localparam int IW = 8;
   localparam int TO = 32;

   logic                 clk;
   logic                 rstn;
   logic [1:0]           rd_i;
   logic [1:0]           wr_i;
   logic [1:0][TW-1:0]   tag_i;
   logic [1:0][IW-1:0]   index_i;
   logic [1:0][TW-1:0]   wtag_i;
   logic [1:0][LW-1:0]   wdata_i;
   logic [LW-1:0]        rdata_o;
   logic [1:0]           ready_o;
   logic [1:0]           grant_o;
   logic                 err_o;
   logic                 read_L2_MEM;
   logic                 write_L2_MEM;
   logic [TW-1:0]        tag_L2_MEM;
   logic [IW-1:0]        index_L2_MEM;
   logic [TW-1:0]        write_tag_L2_MEM;
   logic [LW-1:0]        write_data_L2_MEM;
   logic [LW-1:0]        read_data_MEM_L2;
   logic                 ready_MEM_L2;

   int checks = 0;
   int errors = 0;

   // Reference model state: who won last, sticky error, last returned line.
   bit            lastGrant;
   bit            errModel;
   logic [LW-1:0] rdataModel;

   dram_port_arbiter #(
      .LINE_W      (LW),
      .TAG_W       (TW),
      .INDEX_W     (IW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .rd_i              (rd_i),
      .wr_i              (wr_i),
      .tag_i             (tag_i),
      .index_i           (index_i),
      .wtag_i            (wtag_i),
      .wdata_i           (wdata_i),
      .rdata_o           (rdata_o),
      .ready_o           (ready_o),
      .grant_o           (grant_o),
      .err_o             (err_o),
      .read_L2_MEM       (read_L2_MEM),
      .write_L2_MEM      (write_L2_MEM),
      .tag_L2_MEM        (tag_L2_MEM),
      .index_L2_MEM      (index_L2_MEM),
      .write_tag_L2_MEM  (write_tag_L2_MEM),
      .write_data_L2_MEM (write_data_L2_MEM),
      .read_data_MEM_L2  (read_data_MEM_L2),
      .ready_MEM_L2      (ready_MEM_L2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] randLine();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic randReq(input int r);
      logic [1:0] kind;
      kind       = 2'($urandom_range(1, 3));
      rd_i[r]    = kind[0];
      wr_i[r]    = kind[1];
      tag_i[r]   = TW'($urandom());
      index_i[r] = IW'($urandom());
      wtag_i[r]  = TW'($urandom());
      wdata_i[r] = randLine();
   endtask

   task automatic checkIdleOutputs(input string name);
      check({name, "_grant"}, LW'(grant_o), LW'(0));
      check({name, "_ready"}, LW'(ready_o), LW'(0));
      check({name, "_cmd"}, LW'({read_L2_MEM, write_L2_MEM}), LW'(0));
   endtask

   // Serve one transaction: the model picks the winner from the currently
   // held requests, the controller answers d cycles into BUSY (or never if
   // d reaches the timeout), and the winner drops its request after ready_o.
   task automatic serveOne(input int d, input logic [LW-1:0] memData, input bit scramble);
      logic [1:0]    req;
      int            w;
      bit            timedOut;
      bit            last;
      logic          expRd, expWr;
      logic [TW-1:0] expTag, expWtag;
      logic [IW-1:0] expIdx;
      logic [LW-1:0] expWdata;
      logic [1:0]    expGrant;

      req = {rd_i[1] | wr_i[1], rd_i[0] | wr_i[0]};
      if (req == 2'b00) begin
         errors++;
         $display("[TB] FAIL serve_no_request: observed 0 expected nonzero");
         return;
      end
      if (req == 2'b11) w = (lastGrant == 1'b1) ? 0 : 1;
      else              w = req[1] ? 1 : 0;
      expRd    = rd_i[w];
      expWr    = wr_i[w];
      expTag   = tag_i[w];
      expIdx   = index_i[w];
      expWtag  = wtag_i[w];
      expWdata = wdata_i[w];
      expGrant = 2'b01 << w;
      timedOut = (d >= TO);
      lastGrant = (w == 1);

      @(posedge clk); #1;
      for (int k = 0; k < TO; k++) begin
         last             = (k == d) || (k == TO - 1);
         ready_MEM_L2     = (k == d);
         read_data_MEM_L2 = (k == d) ? memData : randLine();
         if (scramble && k == 0) begin
            tag_i[w]   = ~tag_i[w];
            wdata_i[w] = ~wdata_i[w];
         end
         @(negedge clk);
         check("busy_ready", LW'(ready_o), LW'(0));
         if (k == 0 || last) begin
            check("busy_grant", LW'(grant_o), LW'(expGrant));
            check("busy_rd", LW'(read_L2_MEM), LW'(expRd));
            check("busy_wr", LW'(write_L2_MEM), LW'(expWr));
            check("busy_tag", LW'(tag_L2_MEM), LW'(expTag));
            check("busy_idx", LW'(index_L2_MEM), LW'(expIdx));
            check("busy_wtag", LW'(write_tag_L2_MEM), LW'(expWtag));
            check("busy_wdata", write_data_L2_MEM, expWdata);
         end
         @(posedge clk); #1;
         if (last) break;
      end
      ready_MEM_L2 = 1'b0;

      errModel   = errModel | timedOut;
      rdataModel = timedOut ? '0 : memData;
      @(negedge clk);
      check("done_ready", LW'(ready_o), LW'(expGrant));
      check("done_grant", LW'(grant_o), LW'(expGrant));
      check("done_rdata", rdata_o, rdataModel);
      check("done_err", LW'(err_o), LW'(errModel));
      check("done_cmd", LW'({read_L2_MEM, write_L2_MEM}), LW'(0));

      @(posedge clk); #1;
      rd_i[w] = 1'b0;
      wr_i[w] = 1'b0;
      ready_MEM_L2 = 1'b1;
      @(negedge clk);
      checkIdleOutputs("idle_after");
      check("idle_rdata_held", rdata_o, rdataModel);
      ready_MEM_L2 = 1'b0;
   endtask

   // Linear directed sequence followed by random transactions and a mid-transaction reset.
   initial begin
      logic [LW-1:0] line1;

      rstn = 1'b0;
      rd_i = '0; wr_i = '0; tag_i = '0; index_i = '0; wtag_i = '0; wdata_i = '0;
      read_data_MEM_L2 = '0; ready_MEM_L2 = 1'b0;
      lastGrant = 1'b1; errModel = 1'b0; rdataModel = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkIdleOutputs("reset");
      check("reset_err", LW'(err_o), LW'(0));
      check("reset_rdata", rdata_o, '0);
      check("reset_fields", LW'({tag_L2_MEM, index_L2_MEM, write_tag_L2_MEM}), LW'(0));
      @(posedge clk); #1;
      rstn = 1'b1;

      // Single read from requester 0; command appears one cycle after request.
      @(posedge clk); #1;
      line1 = {8{64'h0123_4567_89AB_5632}};
      rd_i[0] = 1'b1; tag_i[0] = 18'h000A5; index_i[0] = 8'h12;
      @(negedge clk);
      check("t1_no_cmd_yet", LW'(read_L2_MEM), LW'(0));
      serveOne(20, line1, 1'b0);

      // Simultaneous requests: alternation by round robin.
      @(posedge clk); #1;
      randReq(0); rd_i[0] = 1'b1; wr_i[0] = 1'b0;
      randReq(1); rd_i[1] = 1'b0; wr_i[1] = 1'b1;
      serveOne(2, randLine(), 1'b0);
      serveOne(3, randLine(), 1'b0);
      randReq(0); randReq(1);
      serveOne(1, randLine(), 1'b0);
      serveOne(0, randLine(), 1'b0);

      // Evict+fill on requester 1.
      randReq(1);
      rd_i[1] = 1'b1; wr_i[1] = 1'b1; tag_i[1] = 18'h00011; wtag_i[1] = 18'h3FF00;
      serveOne(5, randLine(), 1'b0);

      // Requester changes its fields while granted.
      randReq(0);
      serveOne(4, randLine(), 1'b1);

      // Controller never answers: timeout, then a normal transaction.
      randReq(0); rd_i[0] = 1'b1;
      serveOne(TO + 5, randLine(), 1'b0);
      randReq(1);
      serveOne(6, randLine(), 1'b0);

      for (int i = 0; i < 14; i++) begin
         for (int r = 0; r < 2; r++) begin
            if (!(rd_i[r] | wr_i[r]) && $urandom_range(0, 1) == 1) randReq(r);
         end
         if ((rd_i | wr_i) == 2'b00) randReq(int'($urandom_range(0, 1)));
         serveOne(int'($urandom_range(0, TO + 3)), randLine(), 1'($urandom_range(0, 1)));
      end
      if ((rd_i | wr_i) != 2'b00) serveOne(3, randLine(), 1'b0);

      // Reset in the middle of a transaction.
      randReq(0); rd_i[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_busy_grant", LW'(grant_o), LW'(2'b01));
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      checkIdleOutputs("rst_async");
      check("rst_async_err", LW'(err_o), LW'(0));
      check("rst_async_rdata", rdata_o, '0);
      check("rst_async_fields", LW'({tag_L2_MEM, index_L2_MEM}), LW'(0));
      rd_i = '0; wr_i = '0;
      lastGrant = 1'b1; errModel = 1'b0; rdataModel = '0;
      @(posedge clk); #1;
      rstn = 1'b1;
      ready_MEM_L2 = 1'b1;
      read_data_MEM_L2 = randLine();
      @(posedge clk); #1;
      ready_MEM_L2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkIdleOutputs("rst_late_ready");
      end

      // After reset requester 0 wins the first tie again.
      @(posedge clk); #1;
      randReq(0); randReq(1);
      serveOne(2, randLine(), 1'b0);
      serveOne(2, randLine(), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
